// File: rtl/ii_frame_builder.sv
// Builds a 20-bit integral image from a raster stream of 4-bit pixels into an
// internal RAM, then hands the frame to a face-detection cascade and latches its verdict.
module ii_frame_builder #(
    parameter int II_WIDTH  = 160,
    parameter int II_HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [3:0]  pix_data,
    output logic        pix_ready,
    input  logic [14:0] rd_addr,
    output logic [20:0] rd_data,
    output logic        detect_en,
    input  logic        detect_done,
    input  logic        detected_flag,
    output logic        face_flag,
    output logic        result_valid,
    output logic        busy,
    output logic        frame_err,
    output logic [1:0]  state_dbg
);

    localparam int DEPTH = II_WIDTH * II_HEIGHT;
    localparam int XW    = (II_WIDTH  > 1) ? $clog2(II_WIDTH)  : 1;
    localparam int YW    = (II_HEIGHT > 1) ? $clog2(II_HEIGHT) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(II_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(II_HEIGHT - 1);
    localparam logic [15:0]   DEPTH_L = 16'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUILD  = 2'd1,
        S_DETECT = 2'd2
    } state_t;

    state_t      state_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [19:0] row_sum_q;
    logic [14:0] wr_addr_q;
    logic        pix_ready_q;
    logic        detect_en_q;
    logic        busy_q;
    logic        face_flag_q;
    logic        result_valid_q;
    logic        frame_err_q;
    logic [20:0] rd_data_q;

    logic [19:0] mem      [0:DEPTH-1];
    logic [19:0] line_buf [0:II_WIDTH-1];

    logic        accept;
    logic        last_px;
    logic [19:0] above_d;
    logic [19:0] row_sum_d;
    logic [19:0] ii_d;

    // A pixel coinciding with frame_start is dropped: the restart wins.
    assign accept    = (state_q == S_BUILD) && pix_valid && !frame_start;
    assign last_px   = (x_q == X_LAST) && (y_q == Y_LAST);
    assign above_d   = (y_q == '0) ? 20'd0 : line_buf[x_q];
    assign row_sum_d = row_sum_q + {16'd0, pix_data};
    assign ii_d      = row_sum_d + above_d;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr_q]  <= ii_d;
            line_buf[x_q]   <= ii_d;
        end
    end

    // Registered read port; nonblocking update gives read-old-data on collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if ({1'b0, rd_addr} < DEPTH_L) begin
            rd_data_q <= {1'b0, mem[rd_addr]};
        end else begin
            rd_data_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            x_q            <= '0;
            y_q            <= '0;
            row_sum_q      <= '0;
            wr_addr_q      <= '0;
            pix_ready_q    <= 1'b0;
            detect_en_q    <= 1'b0;
            busy_q         <= 1'b0;
            face_flag_q    <= 1'b0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            // detect_en trails the DETECT state by one cycle on both edges.
            detect_en_q    <= (state_q == S_DETECT);
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        state_q     <= S_BUILD;
                        x_q         <= '0;
                        y_q         <= '0;
                        row_sum_q   <= '0;
                        wr_addr_q   <= '0;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_BUILD: begin
                    if (frame_start) begin
                        frame_err_q <= 1'b1;
                        x_q         <= '0;
                        y_q         <= '0;
                        row_sum_q   <= '0;
                        wr_addr_q   <= '0;
                    end else if (accept) begin
                        wr_addr_q <= wr_addr_q + 15'd1;
                        if (x_q == X_LAST) begin
                            x_q       <= '0;
                            y_q       <= y_q + 1'b1;
                            row_sum_q <= '0;
                        end else begin
                            x_q       <= x_q + 1'b1;
                            row_sum_q <= row_sum_d;
                        end
                        if (last_px) begin
                            state_q     <= S_DETECT;
                            pix_ready_q <= 1'b0;
                            y_q         <= '0;
                        end
                    end
                end
                S_DETECT: begin
                    if (detect_done) begin
                        state_q        <= S_IDLE;
                        face_flag_q    <= detected_flag;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    pix_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pix_ready    = pix_ready_q;
    assign rd_data      = rd_data_q;
    assign detect_en    = detect_en_q;
    assign face_flag    = face_flag_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign frame_err    = frame_err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ii_frame_builder.sv
// Directed bench for ii_frame_builder: three frames (all-ones, aborted+all-ones,
// all-15 with gapped valid), table-driven RAM reads, detect handshake and reset.
module tb_ii_frame_builder;

  localparam int W     = 160;
  localparam int H     = 120;
  localparam int DEPTH = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [3:0]  pix_data = '0;
  logic        pix_ready;
  logic [14:0] rd_addr = '0;
  logic [20:0] rd_data;
  logic        detect_en;
  logic        detect_done = 1'b0;
  logic        detected_flag = 1'b0;
  logic        face_flag;
  logic        result_valid;
  logic        busy;
  logic        frame_err;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          grp;
    logic [14:0] addr;
    logic [20:0] exp;
  } rd_vec_t;

  rd_vec_t tbl[$];

  ii_frame_builder #(.II_WIDTH(W), .II_HEIGHT(H)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .detect_en     (detect_en),
    .detect_done   (detect_done),
    .detected_flag (detected_flag),
    .face_flag     (face_flag),
    .result_valid  (result_valid),
    .busy          (busy),
    .frame_err     (frame_err),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_rd(input int g, input int a, input int e);
    rd_vec_t v;
    v.grp  = g;
    v.addr = 15'(a);
    v.exp  = 21'(e);
    tbl.push_back(v);
  endtask

  // Back-to-back reads: each result must appear exactly one edge after its address.
  task automatic run_reads(input int g);
    foreach (tbl[k]) begin
      if (tbl[k].grp == g) begin
        rd_addr = tbl[k].addr;
        tick();
        chk($sformatf("rd_g%0d_a%0d", g, tbl[k].addr), rd_data, tbl[k].exp);
      end
    end
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("start_ready", pix_ready, 1);
    chk("start_busy", busy, 1);
  endtask

  // old0 >= 0: rd_addr is held at 0 and the read during the first write must return old0.
  task automatic run_frame(input logic [3:0] val, input bit toggle, input int old0);
    for (int i = 0; i < DEPTH; i++) begin
      if (toggle) begin
        pix_valid = 1'b0;
        pix_data  = 4'($urandom_range(0, 15));
        tick();
      end
      pix_valid = 1'b1;
      pix_data  = val;
      if (i == 100) chk("ready_mid", pix_ready, 1);
      tick();
      if (old0 >= 0 && i == 0) chk("ram_read_old", rd_data, 21'(old0));
      if (old0 >= 0 && i == 1) chk("ram_read_new", rd_data, 21'(val));
    end
    pix_valid = 1'b0;
    chk("ready_drop", pix_ready, 0);
    chk("busy_detect", busy, 1);
    chk("en_not_yet", detect_en, 0);
    tick();
    chk("en_rise", detect_en, 1);
  endtask

  task automatic finish_detect(input logic flag);
    int n = 0;
    while (!detect_en && n < 8) begin
      tick();
      n++;
    end
    chk("detect_en_wait", detect_en, 1);
    detect_done   = 1'b1;
    detected_flag = flag;
    tick();
    detect_done   = 1'b0;
    detected_flag = 1'b0;
    chk("res_valid_hi", result_valid, 1);
    chk("face_flag", face_flag, flag);
    chk("busy_after_done", busy, 0);
    tick();
    chk("res_valid_lo", result_valid, 0);
    chk("en_low_after", detect_en, 0);
    chk("face_flag_held", face_flag, flag);
  endtask

  initial begin
    // all-ones frame: ii(x,y) = (x+1)*(y+1)
    add_rd(0, 0, 1);       add_rd(0, 159, 160);   add_rd(0, 160, 2);
    add_rd(0, 161, 4);     add_rd(0, 1000, 287);  add_rd(0, 19040, 120);
    add_rd(0, 19199, 19200); add_rd(0, 19200, 0); add_rd(0, 32767, 0);
    add_rd(0, 319, 320);
    add_rd(1, 19199, 19200); add_rd(1, 32767, 0); add_rd(1, 0, 1);
    add_rd(2, 19199, 19200); add_rd(2, 500, 84);  add_rd(2, 0, 1);
    add_rd(2, 19200, 0);
    // all-15 frame: ii(x,y) = 15*(x+1)*(y+1)
    add_rd(3, 19199, 288000); add_rd(3, 0, 15);   add_rd(3, 159, 2400);
    add_rd(3, 160, 30);       add_rd(3, 161, 60); add_rd(3, 19200, 0);
    add_rd(4, 19199, 288000); add_rd(4, 1, 30);

    // reset state
    #12;
    chk("rst_ready", pix_ready, 0);
    chk("rst_en", detect_en, 0);
    chk("rst_face", face_flag, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rd_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // detect_done in IDLE is ignored
    detect_done = 1'b1; detected_flag = 1'b1;
    tick();
    detect_done = 1'b0; detected_flag = 1'b0;
    chk("idle_done_rv", result_valid, 0);
    chk("idle_done_face", face_flag, 0);
    chk("idle_ready", pix_ready, 0);

    // frame A: start pulse carries a pixel that must not be taken
    pix_valid = 1'b1; pix_data = 4'd9;
    start_frame();
    pix_valid = 1'b0;
    run_frame(4'd1, 1'b0, -1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("det_start_err", frame_err, 0);
    chk("det_start_busy", busy, 1);
    chk("det_start_ready", pix_ready, 0);
    chk("det_start_en", detect_en, 1);
    run_reads(0);
    finish_detect(1'b1);
    run_reads(1);

    // frame B: abort after 500 pixels, then a full all-ones frame
    start_frame();
    for (int i = 0; i < 500; i++) begin
      pix_valid = 1'b1; pix_data = 4'd1;
      tick();
    end
    frame_start = 1'b1; pix_valid = 1'b1; pix_data = 4'd15;
    tick();
    frame_start = 1'b0; pix_valid = 1'b0;
    chk("abort_err", frame_err, 1);
    chk("abort_ready", pix_ready, 1);
    chk("abort_busy", busy, 1);
    tick();
    chk("abort_err_pulse", frame_err, 0);
    run_frame(4'd1, 1'b0, -1);
    run_reads(2);
    finish_detect(1'b0);

    // frame C: all-15 at 50% valid, read-old-data on the first write
    rd_addr = '0;
    start_frame();
    run_frame(4'd15, 1'b1, 1);
    run_reads(3);

    // reset during DETECT
    rst_n = 1'b0;
    #1;
    chk("arst_en", detect_en, 0);
    chk("arst_face", face_flag, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", pix_ready, 0);
    chk("arst_rdata", rd_data, 0);
    chk("arst_rv", result_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    detect_done = 1'b1; detected_flag = 1'b1;
    tick();
    detect_done = 1'b0; detected_flag = 1'b0;
    chk("post_rst_rv", result_valid, 0);
    chk("post_rst_face", face_flag, 0);
    chk("post_rst_en", detect_en, 0);
    run_reads(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
